// File: rtl/nnrv_ram_if.sv
// nnrv_ram_if: bundles the nnrv_ram read, write and program-loader signals.
//   slave  modport: used by the RAM (requests in, read data / loader status out)
//   master modport: used by whoever drives the RAM (core datapath, loader host)
// Optional output o_align_err exists only when NNRV_RAM_ALIGN_CHK_EN is defined.
interface nnrv_ram_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    // Read port (fetch stage)
    logic [ADDR_WIDTH-1:0] i_rd_addr;
    logic                  i_rd_en;
    logic [3:0]            i_rd_mask;
    logic [DATA_WIDTH-1:0] o_rd_data;
    // Byte-masked write port (datapath)
    logic [ADDR_WIDTH-1:0] i_wr_addr;
    logic                  i_wr_en;
    logic [3:0]            i_wr_mask;
    logic [DATA_WIDTH-1:0] i_wr_data;
    // Byte-serial program loader
    logic                  i_ld_start;
    logic                  i_ld_valid;
    logic [7:0]            i_ld_byte;
    logic                  i_ld_last;
    logic                  o_ld_busy;
    logic                  o_ld_done;
    logic                  o_ld_ovf;
`ifdef NNRV_RAM_ALIGN_CHK_EN
    logic                  o_align_err;
`endif

    modport slave (
        input  i_rd_addr, i_rd_en, i_rd_mask,
        input  i_wr_addr, i_wr_en, i_wr_mask, i_wr_data,
        input  i_ld_start, i_ld_valid, i_ld_byte, i_ld_last,
        output o_rd_data, o_ld_busy, o_ld_done, o_ld_ovf
`ifdef NNRV_RAM_ALIGN_CHK_EN
        , output o_align_err
`endif
    );

    modport master (
        output i_rd_addr, i_rd_en, i_rd_mask,
        output i_wr_addr, i_wr_en, i_wr_mask, i_wr_data,
        output i_ld_start, i_ld_valid, i_ld_byte, i_ld_last,
        input  o_rd_data, o_ld_busy, o_ld_done, o_ld_ovf
`ifdef NNRV_RAM_ALIGN_CHK_EN
        , input o_align_err
`endif
    );
endinterface

// File: rtl/nnrv_ram.sv
// nnrv_ram: word-organised memory for the nnrv core.
//   - combinational byte-masked read port (fetch stage)
//   - synchronous byte-masked write port (datapath), blocked while loading
//   - byte-serial program loader FSM (IDLE -> LOAD -> DONE) filling from byte 0
// Ports:
//   i_clk  clock
//   i_rst  synchronous active-high reset (memory contents are not cleared)
//   bus    nnrv_ram_if.slave: rd_*, wr_*, ld_* requests; o_rd_data, o_ld_busy,
//          o_ld_done (one-cycle pulse), o_ld_ovf (sticky pointer wrap)
// Optional: define NNRV_RAM_ALIGN_CHK_EN to add registered o_align_err, flagging
// accesses with an illegal mask or an address not matching the mask's low lane.
module nnrv_ram #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic      i_clk,
    input  logic      i_rst,
    nnrv_ram_if.slave bus
);
    localparam int unsigned LANES   = 4;
    localparam int unsigned WORD_AW = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH   = 1 << WORD_AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  ovf_q, ovf_d;
    logic                  ld_we_c;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [WORD_AW-1:0]    we_word_c;
    logic [LANES-1:0]      we_mask_c;
    logic [DATA_WIDTH-1:0] we_data_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic [DATA_WIDTH-1:0] rd_data_c;

    // Loader state, pointer and sticky overflow registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
        end
    end

    // Loader next-state; a start in any state (re)starts the load at byte 0
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ovf_d   = ovf_q;
        ld_we_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_ld_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (bus.i_ld_start) begin
                    ptr_d = '0;
                    ovf_d = 1'b0;
                end else if (bus.i_ld_valid) begin
                    ld_we_c = 1'b1;
                    ptr_d   = ptr_q + ADDR_WIDTH'(1);
                    if (ptr_q == '1) begin
                        ovf_d = 1'b1;
                    end
                    if (bus.i_ld_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.i_ld_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Single write port: loader byte while loading, else datapath write
    always_comb begin
        we_word_c = bus.i_wr_addr[ADDR_WIDTH-1:2];
        we_mask_c = '0;
        we_data_c = bus.i_wr_data;
        if (ld_we_c) begin
            we_word_c = ptr_q[ADDR_WIDTH-1:2];
            we_mask_c = LANES'(1) << ptr_q[1:0];
            we_data_c = DATA_WIDTH'({LANES{bus.i_ld_byte}});
        end else if (bus.i_wr_en && (state_q != ST_LOAD)) begin
            we_mask_c = bus.i_wr_mask;
        end
    end

    // Memory array, byte-lane write enables, no reset
    always_ff @(posedge i_clk) begin
        for (int n = 0; n < LANES; n++) begin
            if (we_mask_c[n]) begin
                mem_q[we_word_c][8*n +: 8] <= we_data_c[8*n +: 8];
            end
        end
    end

    // Combinational read; pre-edge contents are seen during a same-word write
    always_comb begin
        rd_word_c = mem_q[bus.i_rd_addr[ADDR_WIDTH-1:2]];
        rd_data_c = '0;
        for (int n = 0; n < LANES; n++) begin
            if (bus.i_rd_en && bus.i_rd_mask[n]) begin
                rd_data_c[8*n +: 8] = rd_word_c[8*n +: 8];
            end
        end
    end

    assign bus.o_rd_data = rd_data_c;
    assign bus.o_ld_busy = (state_q == ST_LOAD);
    assign bus.o_ld_done = (state_q == ST_DONE);
    assign bus.o_ld_ovf  = ovf_q;

`ifdef NNRV_RAM_ALIGN_CHK_EN
    logic align_err_q, align_err_d;

    // Flags a mask outside {single byte, low half, high half, full word}
    // or an address whose byte offset differs from the mask's lowest lane
    function automatic logic access_bad(input logic [1:0] ofs, input logic [3:0] mask);
        logic       legal;
        logic [1:0] low;
        case (mask)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: legal = 1'b1;
            default:                   legal = 1'b0;
        endcase
        if (mask[0])      low = 2'd0;
        else if (mask[1]) low = 2'd1;
        else if (mask[2]) low = 2'd2;
        else              low = 2'd3;
        return !legal || (ofs != low);
    endfunction

    always_comb begin
        align_err_d = (bus.i_rd_en && access_bad(bus.i_rd_addr[1:0], bus.i_rd_mask)) ||
                      (bus.i_wr_en && access_bad(bus.i_wr_addr[1:0], bus.i_wr_mask));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end

    assign bus.o_align_err = align_err_q;
`else
    // Byte offsets only matter to the alignment checker
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.i_rd_addr[1:0], bus.i_wr_addr[1:0]};
`endif

endmodule

// File: tb/tb_nnrv_ram.sv
// tb_nnrv_ram: directed self-checking bench for nnrv_ram.
// Two instances: 8-bit byte address (main tests) and 4-bit (loader wrap test).
module tb_nnrv_ram;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    nnrv_ram_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();
    nnrv_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus4 ();

    nnrv_ram #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    nnrv_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) u_dut4 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_rd_addr  = '0; bus.i_rd_en  = 1'b0; bus.i_rd_mask  = '0;
        bus.i_wr_addr  = '0; bus.i_wr_en  = 1'b0; bus.i_wr_mask  = '0; bus.i_wr_data = '0;
        bus.i_ld_start = 1'b0; bus.i_ld_valid = 1'b0; bus.i_ld_byte = '0; bus.i_ld_last = 1'b0;
        bus4.i_rd_addr  = '0; bus4.i_rd_en  = 1'b0; bus4.i_rd_mask  = '0;
        bus4.i_wr_addr  = '0; bus4.i_wr_en  = 1'b0; bus4.i_wr_mask  = '0; bus4.i_wr_data = '0;
        bus4.i_ld_start = 1'b0; bus4.i_ld_valid = 1'b0; bus4.i_ld_byte = '0; bus4.i_ld_last = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (bus.o_ld_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus.o_ld_busy); end
        total++;
        if (bus.o_ld_done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", bus.o_ld_done); end
        total++;
        if (bus.o_ld_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got %b want 0", bus.o_ld_ovf); end
        total++;
        if (bus4.o_ld_busy !== 1'b0) begin bad++; $display("FAIL reset_busy4 got %b want 0", bus4.o_ld_busy); end
`ifdef NNRV_RAM_ALIGN_CHK_EN
        total++;
        if (bus.o_align_err !== 1'b0) begin bad++; $display("FAIL reset_align got %b want 0", bus.o_align_err); end
`endif
    endtask

    task automatic test_word_write();
        bus.i_wr_addr = 8'h04; bus.i_wr_mask = 4'b1111; bus.i_wr_data = 32'hDEADBEEF; bus.i_wr_en = 1'b1;
        tick();
        bus.i_wr_en = 1'b0;
        bus.i_rd_addr = 8'h04; bus.i_rd_mask = 4'b1111; bus.i_rd_en = 1'b1;
        #1;
        total++;
        if (bus.o_rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_full got %h want DEADBEEF", bus.o_rd_data); end
        bus.i_rd_mask = 4'b0011;
        #1;
        total++;
        if (bus.o_rd_data !== 32'h0000BEEF) begin bad++; $display("FAIL rd_mask0011 got %h want 0000BEEF", bus.o_rd_data); end
        bus.i_rd_mask = 4'b1000;
        #1;
        total++;
        if (bus.o_rd_data !== 32'hDE000000) begin bad++; $display("FAIL rd_mask1000 got %h want DE000000", bus.o_rd_data); end
        bus.i_rd_mask = 4'b1111; bus.i_rd_en = 1'b0;
        #1;
        total++;
        if (bus.o_rd_data !== 32'h0) begin bad++; $display("FAIL rd_disabled got %h want 00000000", bus.o_rd_data); end
        bus.i_rd_addr = 8'h07; bus.i_rd_en = 1'b1;
        #1;
        total++;
        if (bus.o_rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_ofs_ignored got %h want DEADBEEF", bus.o_rd_data); end
        bus.i_rd_en = 1'b0;
        tick();
    endtask

    task automatic test_byte_write();
        bus.i_wr_addr = 8'h08; bus.i_wr_mask = 4'b1111; bus.i_wr_data = 32'h11223344; bus.i_wr_en = 1'b1;
        tick();
        bus.i_wr_mask = 4'b0100; bus.i_wr_data = 32'hAABBCCDD;
        bus.i_rd_addr = 8'h08; bus.i_rd_mask = 4'b1111; bus.i_rd_en = 1'b1;
        #1;
        total++;
        if (bus.o_rd_data !== 32'h11223344) begin bad++; $display("FAIL rdw_old got %h want 11223344", bus.o_rd_data); end
        tick();
        bus.i_wr_en = 1'b0;
        #1;
        total++;
        if (bus.o_rd_data !== 32'h11BB3344) begin bad++; $display("FAIL byte_merge got %h want 11BB3344", bus.o_rd_data); end
        bus.i_rd_en = 1'b0;
        tick();
    endtask

    task automatic test_loader();
        logic [7:0] prog [8];
        prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h00;
        prog[4] = 8'h93; prog[5] = 8'h00; prog[6] = 8'h10; prog[7] = 8'h00;
        bus.i_ld_start = 1'b1;
        tick();
        bus.i_ld_start = 1'b0;
        // datapath write to word 0 while loading must be dropped
        bus.i_wr_addr = 8'h00; bus.i_wr_mask = 4'b1111; bus.i_wr_data = 32'hFFFFFFFF; bus.i_wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.i_ld_valid = 1'b1; bus.i_ld_byte = prog[i]; bus.i_ld_last = (i == 7);
            total++;
            if (bus.o_ld_busy !== 1'b1 || bus.o_ld_done !== 1'b0) begin
                bad++; $display("FAIL ld_busy_byte%0d got busy=%b done=%b want busy=1 done=0", i, bus.o_ld_busy, bus.o_ld_done);
            end
            tick();
        end
        bus.i_ld_valid = 1'b0; bus.i_ld_last = 1'b0; bus.i_wr_en = 1'b0;
        total++;
        if (bus.o_ld_done !== 1'b1 || bus.o_ld_busy !== 1'b0) begin
            bad++; $display("FAIL ld_done_pulse got done=%b busy=%b want done=1 busy=0", bus.o_ld_done, bus.o_ld_busy);
        end
        tick();
        total++;
        if (bus.o_ld_done !== 1'b0) begin bad++; $display("FAIL ld_done_once got %b want 0", bus.o_ld_done); end
        total++;
        if (bus.o_ld_ovf !== 1'b0) begin bad++; $display("FAIL ld_no_ovf got %b want 0", bus.o_ld_ovf); end
        bus.i_rd_en = 1'b1; bus.i_rd_mask = 4'b1111; bus.i_rd_addr = 8'h00;
        #1;
        total++;
        if (bus.o_rd_data !== 32'h00000013) begin bad++; $display("FAIL ld_word0 got %h want 00000013", bus.o_rd_data); end
        bus.i_rd_addr = 8'h04;
        #1;
        total++;
        if (bus.o_rd_data !== 32'h00100093) begin bad++; $display("FAIL ld_word1 got %h want 00100093", bus.o_rd_data); end
        bus.i_rd_en = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        bus4.i_ld_start = 1'b1;
        tick();
        bus4.i_ld_start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus4.i_ld_valid = 1'b1; bus4.i_ld_byte = 8'(i); bus4.i_ld_last = (i == 16);
            tick();
            if (i == 14) begin
                total++;
                if (bus4.o_ld_ovf !== 1'b0) begin bad++; $display("FAIL wrap_early got %b want 0", bus4.o_ld_ovf); end
            end
            if (i == 15) begin
                total++;
                if (bus4.o_ld_ovf !== 1'b1) begin bad++; $display("FAIL wrap_set got %b want 1", bus4.o_ld_ovf); end
            end
        end
        bus4.i_ld_valid = 1'b0; bus4.i_ld_last = 1'b0;
        bus4.i_rd_en = 1'b1; bus4.i_rd_mask = 4'b1111; bus4.i_rd_addr = 4'h0;
        #1;
        total++;
        if (bus4.o_rd_data !== 32'h03020110) begin bad++; $display("FAIL wrap_word0 got %h want 03020110", bus4.o_rd_data); end
        bus4.i_rd_addr = 4'hC;
        #1;
        total++;
        if (bus4.o_rd_data !== 32'h0F0E0D0C) begin bad++; $display("FAIL wrap_word3 got %h want 0F0E0D0C", bus4.o_rd_data); end
        tick();
        tick();
        tick();
        total++;
        if (bus4.o_ld_ovf !== 1'b1 || bus4.o_ld_busy !== 1'b0) begin
            bad++; $display("FAIL wrap_held got ovf=%b busy=%b want ovf=1 busy=0", bus4.o_ld_ovf, bus4.o_ld_busy);
        end
        bus4.i_ld_start = 1'b1;
        tick();
        bus4.i_ld_start = 1'b0;
        total++;
        if (bus4.o_ld_ovf !== 1'b0) begin bad++; $display("FAIL wrap_clear got %b want 0", bus4.o_ld_ovf); end
        bus4.i_ld_valid = 1'b1; bus4.i_ld_byte = 8'hAA; bus4.i_ld_last = 1'b1;
        tick();
        bus4.i_ld_valid = 1'b0; bus4.i_ld_last = 1'b0;
        bus4.i_rd_addr = 4'h0;
        #1;
        total++;
        if (bus4.o_rd_data !== 32'h030201AA) begin bad++; $display("FAIL wrap_reload got %h want 030201AA", bus4.o_rd_data); end
        bus4.i_rd_en = 1'b0;
        tick();
    endtask

    task automatic test_restart_reset();
        logic [7:0] first [3];
        first[0] = 8'hA0; first[1] = 8'hA1; first[2] = 8'hA2;
        bus.i_ld_start = 1'b1;
        tick();
        bus.i_ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.i_ld_valid = 1'b1; bus.i_ld_byte = first[i];
            tick();
        end
        // restart with a byte present: byte must not be written
        bus.i_ld_start = 1'b1; bus.i_ld_byte = 8'hEE;
        tick();
        bus.i_ld_start = 1'b0;
        total++;
        if (bus.o_ld_busy !== 1'b1 || bus.o_ld_done !== 1'b0) begin
            bad++; $display("FAIL restart_state got busy=%b done=%b want busy=1 done=0", bus.o_ld_busy, bus.o_ld_done);
        end
        bus.i_ld_byte = 8'hB0;
        tick();
        bus.i_ld_valid = 1'b0;
        bus.i_rd_en = 1'b1; bus.i_rd_mask = 4'b1111; bus.i_rd_addr = 8'h00;
        #1;
        total++;
        if (bus.o_rd_data !== 32'h00A2A1B0) begin bad++; $display("FAIL restart_byte0 got %h want 00A2A1B0", bus.o_rd_data); end
        // last without valid is ignored
        bus.i_ld_last = 1'b1;
        tick();
        bus.i_ld_last = 1'b0;
        total++;
        if (bus.o_ld_busy !== 1'b1 || bus.o_ld_done !== 1'b0) begin
            bad++; $display("FAIL last_no_valid got busy=%b done=%b want busy=1 done=0", bus.o_ld_busy, bus.o_ld_done);
        end
        bus.i_ld_valid = 1'b1; bus.i_ld_byte = 8'hB1;
        tick();
        bus.i_ld_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus.o_ld_busy !== 1'b0 || bus.o_ld_done !== 1'b0) begin
            bad++; $display("FAIL midload_reset got busy=%b done=%b want busy=0 done=0", bus.o_ld_busy, bus.o_ld_done);
        end
        #1;
        total++;
        if (bus.o_rd_data !== 32'h00A2B1B0) begin bad++; $display("FAIL reset_retains got %h want 00A2B1B0", bus.o_rd_data); end
        bus.i_rd_en = 1'b0;
        // datapath writes work again after the load is abandoned
        bus.i_wr_addr = 8'h00; bus.i_wr_mask = 4'b1000; bus.i_wr_data = 32'h5A000000; bus.i_wr_en = 1'b1;
        tick();
        bus.i_wr_en = 1'b0;
        bus.i_rd_en = 1'b1;
        #1;
        total++;
        if (bus.o_rd_data !== 32'h5AA2B1B0) begin bad++; $display("FAIL post_reset_write got %h want 5AA2B1B0", bus.o_rd_data); end
        bus.i_rd_en = 1'b0;
        tick();
    endtask

`ifdef NNRV_RAM_ALIGN_CHK_EN
    task automatic test_align();
        idle_inputs();
        tick();
        bus.i_rd_en = 1'b1; bus.i_rd_addr = 8'h05; bus.i_rd_mask = 4'b0011;
        tick();
        total++;
        if (bus.o_align_err !== 1'b1) begin bad++; $display("FAIL align_bad got %b want 1", bus.o_align_err); end
        bus.i_rd_addr = 8'h06; bus.i_rd_mask = 4'b1100;
        tick();
        total++;
        if (bus.o_align_err !== 1'b0) begin bad++; $display("FAIL align_ok got %b want 0", bus.o_align_err); end
        bus.i_rd_en = 1'b0;
        bus.i_wr_en = 1'b1; bus.i_wr_addr = 8'h20; bus.i_wr_mask = 4'b0110; bus.i_wr_data = 32'h0;
        tick();
        bus.i_wr_en = 1'b0;
        total++;
        if (bus.o_align_err !== 1'b1) begin bad++; $display("FAIL align_wr_mask got %b want 1", bus.o_align_err); end
        tick();
        total++;
        if (bus.o_align_err !== 1'b0) begin bad++; $display("FAIL align_one_cycle got %b want 0", bus.o_align_err); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        test_reset();
        test_word_write();
        test_byte_write();
        test_loader();
        test_wrap();
        test_restart_reset();
`ifdef NNRV_RAM_ALIGN_CHK_EN
        test_align();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
